// File: rtl/vred_logic_issue_pkg.sv
// Shared encodings and helpers for the logical-reduction issue sequencer.
package vred_logic_issue_pkg;

    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VS1,
        S_STREAM,
        S_DRAIN
    } state_t;

    // AND reduces against all-ones; OR and XOR against zero.
    function automatic logic [63:0] vred_ident(input logic [1:0] op_sel);
        return (op_sel == OP_AND) ? '1 : '0;
    endfunction

    function automatic logic [3:0] vred_epb(input logic [1:0] sew);
        return 4'd8 >> sew;
    endfunction

endpackage

// File: rtl/vred_logic_issue_if.sv
// Request, VRF read and reduction-pipeline beat signals of the issue sequencer.
interface vred_logic_issue_if #(
    parameter int DW   = 64,
    parameter int AW   = 32,
    parameter int VLW  = 11,
    parameter int OPW  = 2,
    parameter int SEWW = 2
);
    logic            req_valid;
    logic            req_ready;
    logic [OPW-1:0]  req_opSel;
    logic [SEWW-1:0] req_sew;
    logic [VLW-1:0]  req_vl;
    logic [AW-1:0]   req_vs2_addr;
    logic [AW-1:0]   req_vs1_addr;
    logic [AW-1:0]   req_vd_addr;
    logic            req_err;

    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;

    logic [DW-1:0]   out_vec0;
    logic [DW-1:0]   out_vec1;
    logic            out_valid;
    logic            out_start;
    logic            out_end;
    logic [OPW-1:0]  out_opSel;
    logic [SEWW-1:0] out_sew;
    logic [AW-1:0]   out_addr;

    modport master (
        output req_valid, req_opSel, req_sew, req_vl, req_vs2_addr, req_vs1_addr, req_vd_addr,
        output rd_data,
        input  req_ready, req_err, rd_en, rd_addr,
        input  out_vec0, out_vec1, out_valid, out_start, out_end, out_opSel, out_sew, out_addr
    );

    modport slave (
        input  req_valid, req_opSel, req_sew, req_vl, req_vs2_addr, req_vs1_addr, req_vd_addr,
        input  rd_data,
        output req_ready, req_err, rd_en, rd_addr,
        output out_vec0, out_vec1, out_valid, out_start, out_end, out_opSel, out_sew, out_addr
    );
endinterface

// File: rtl/vred_tail_mask.sv
// Forces element slots at or beyond the remaining element count to the identity value.
module vred_tail_mask
    import vred_logic_issue_pkg::*;
#(
    parameter int DW  = 64,
    parameter int VLW = 11
) (
    input  logic [DW-1:0]  data,
    input  logic [1:0]     sew,
    input  logic [1:0]     op_sel,
    input  logic [VLW-1:0] rem,
    output logic [DW-1:0]  masked
);
    logic [63:0] id_w;
    assign id_w = vred_ident(op_sel);

    // Each byte belongs to element (byte_index >> sew).
    for (genvar b = 0; b < DW / 8; b++) begin : g_byte
        localparam int unsigned BI = b;
        assign masked[b*8 +: 8] = ((VLW'(BI) >> sew) >= rem) ? id_w[b*8 +: 8] : data[b*8 +: 8];
    end
endmodule

// File: rtl/vred_logic_issue.sv
// Issue sequencer: reads vs1[0] then vs2 from the VRF and streams tail-masked beats gap-free.
module vred_logic_issue
    import vred_logic_issue_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int VL_WIDTH       = 11,
    parameter int OPSEL_WIDTH    = 2,
    parameter int SEW_WIDTH      = 2,
    parameter bit ENABLE_64_BIT  = 1'b1
) (
    input logic            clk,
    input logic            rst,
    vred_logic_issue_if.slave bus
);
    state_t                    state;
    logic [VL_WIDTH-1:0]       k;
    logic [OPSEL_WIDTH-1:0]    op_q;
    logic [SEW_WIDTH-1:0]      sew_q;
    logic [VL_WIDTH-1:0]       vl_q;
    logic [REQ_ADDR_WIDTH-1:0] vs1_q, vs2_q, vd_q;
    logic                      err_q;

    // Read-data alignment stage: describes what rd_data holds this cycle.
    logic                      d_vs1, d_beat, d_last;
    logic [VL_WIDTH-1:0]       d_k;
    logic [REQ_DATA_WIDTH-1:0] vec1_q;

    logic                      o_valid, o_start, o_end;
    logic [REQ_DATA_WIDTH-1:0] o_vec0, o_vec1;
    logic [OPSEL_WIDTH-1:0]    o_op;
    logic [SEW_WIDTH-1:0]      o_sew;
    logic [REQ_ADDR_WIDTH-1:0] o_addr;

    logic                      reject, last;
    logic [1:0]                shamt;
    logic [VL_WIDTH:0]         n_beats;
    logic [VL_WIDTH+2:0]       base;
    logic [VL_WIDTH-1:0]       rem0;
    logic [REQ_DATA_WIDTH-1:0] vec0_m, vec1_m;

    assign reject = (bus.req_opSel == '0) || (bus.req_vl == '0) ||
                    (!ENABLE_64_BIT && bus.req_sew == SEW_WIDTH'(3));

    // N = ceil(vl / EPB) with EPB = 8 >> sew, so divide is a right shift by 3 - sew.
    assign shamt   = 2'd3 - sew_q;
    assign n_beats = ({1'b0, vl_q} + (VL_WIDTH+1)'(vred_epb(sew_q)) - (VL_WIDTH+1)'(1)) >> shamt;
    assign last    = ({1'b0, k} == n_beats - (VL_WIDTH+1)'(1));

    assign base = {3'b000, d_k} << shamt;
    assign rem0 = (base >= {3'b000, vl_q}) ? '0 : VL_WIDTH'({3'b000, vl_q} - base);

    vred_tail_mask #(.DW(REQ_DATA_WIDTH), .VLW(VL_WIDTH)) u_mask_vec0 (
        .data   (bus.rd_data),
        .sew    (sew_q),
        .op_sel (op_q),
        .rem    (rem0),
        .masked (vec0_m)
    );

    vred_tail_mask #(.DW(REQ_DATA_WIDTH), .VLW(VL_WIDTH)) u_mask_vec1 (
        .data   (bus.rd_data),
        .sew    (sew_q),
        .op_sel (op_q),
        .rem    (VL_WIDTH'(1)),
        .masked (vec1_m)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k       <= '0;
            op_q    <= '0;
            sew_q   <= '0;
            vl_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            err_q   <= 1'b0;
            d_vs1   <= 1'b0;
            d_beat  <= 1'b0;
            d_last  <= 1'b0;
            d_k     <= '0;
            vec1_q  <= '0;
            o_valid <= 1'b0;
            o_start <= 1'b0;
            o_end   <= 1'b0;
            o_vec0  <= '0;
            o_vec1  <= '0;
            o_op    <= '0;
            o_sew   <= '0;
            o_addr  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q  <= bus.req_opSel;
                            sew_q <= bus.req_sew;
                            vl_q  <= bus.req_vl;
                            vs1_q <= bus.req_vs1_addr;
                            vs2_q <= bus.req_vs2_addr;
                            vd_q  <= bus.req_vd_addr;
                            state <= S_VS1;
                        end
                    end
                end
                S_VS1: begin
                    k     <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (last) begin
                        k     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        k <= k + VL_WIDTH'(1);
                    end
                end
                S_DRAIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            d_vs1  <= (state == S_VS1);
            d_beat <= (state == S_STREAM);
            d_k    <= k;
            d_last <= last;
            if (d_vs1) vec1_q <= vec1_m;

            o_valid <= d_beat;
            o_start <= d_beat && (d_k == '0);
            o_end   <= d_beat && d_last;
            o_vec0  <= d_beat ? vec0_m : '0;
            o_vec1  <= d_beat ? vec1_q : '0;
            o_op    <= d_beat ? op_q : '0;
            o_sew   <= d_beat ? sew_q : '0;
            o_addr  <= d_beat ? vd_q : '0;
        end
    end

    // Outputs are forced low while rst is held, even in its first cycle.
    assign bus.req_ready = !rst && (state == S_IDLE);
    assign bus.req_err   = !rst && err_q;
    assign bus.rd_en     = !rst && (state == S_VS1 || state == S_STREAM);
    assign bus.rd_addr   = rst                 ? '0 :
                           (state == S_VS1)    ? vs1_q :
                           (state == S_STREAM) ? vs2_q + REQ_ADDR_WIDTH'(k) : '0;
    assign bus.out_valid = !rst && o_valid;
    assign bus.out_start = !rst && o_start;
    assign bus.out_end   = !rst && o_end;
    assign bus.out_vec0  = rst ? '0 : o_vec0;
    assign bus.out_vec1  = rst ? '0 : o_vec1;
    assign bus.out_opSel = rst ? '0 : o_op;
    assign bus.out_sew   = rst ? '0 : o_sew;
    assign bus.out_addr  = rst ? '0 : o_addr;
endmodule
